spi_responder: RTL and testbench

Synchronous SPI responder (slave) for the same-clock-domain SPI master in the control-register block: it consumes SPI_clk/SPI_mosi and drives SPI_miso. It sits beside the core on the same clk, receives MSB-first frames of 8/16/32 bits into an RX FIFO, and supplies reply words from a TX FIFO. The protocol has no chip select, so frames are delimited by a bit count plus an idle timeout.

---
 rtl/spi_responder.sv | 200 ++++++++++++++++++++
 tb/tb_spi_responder.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_responder.sv
// SPI responder on the core clock: shifts MSB-first 8/16/32-bit frames into an RX FIFO
// and replies from a TX FIFO. Frames end on a bit count, or are aborted by an idle timeout.
module spi_responder #(
  parameter int FIFO_DEPTH   = 2,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IN_SPI_clk,
  input  logic        IN_SPI_mosi,
  output logic        OUT_SPI_miso,
  input  logic [1:0]  IN_frameLen,
  input  logic        IN_txValid,
  input  logic [31:0] IN_txData,
  output logic        OUT_txReady,
  output logic        OUT_rxValid,
  output logic [31:0] OUT_rxData,
  input  logic        IN_rxReady,
  output logic        OUT_rxOverflow,
  output logic        OUT_txUnderflow,
  output logic        OUT_frameErr,
  output logic        OUT_busy
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state, state_next;
  logic            prev_clk;
  logic            rise;
  logic [1:0]      len_q, len_sel;
  logic [4:0]      bit_cnt, last_bit;
  logic [TW-1:0]   to_cnt;
  logic [31:0]     rx_sr, tx_sr, rx_shift, rx_word;
  logic            tx_loaded;

  logic            first_edge, complete, timeout, idle_load;
  logic            tx_push, tx_pop, rx_push, rx_pop, rx_full, tx_nonempty, ovf_evt;

  logic [31:0]     tx_mem [FIFO_DEPTH];
  logic [31:0]     rx_mem [FIFO_DEPTH];
  logic [PW-1:0]   tx_wr, tx_rd, rx_wr, rx_rd;
  logic [CW-1:0]   tx_count, rx_count;

  assign rise     = IN_SPI_clk & ~prev_clk;
  assign len_sel  = (state == IDLE) ? IN_frameLen : len_q;
  assign rx_shift = {rx_sr[30:0], IN_SPI_mosi};

  assign tx_nonempty = (tx_count != '0);
  assign rx_full     = (rx_count == CW'(FIFO_DEPTH));
  assign tx_push     = IN_txValid & OUT_txReady;
  assign rx_pop      = OUT_rxValid & IN_rxReady;
  assign tx_pop      = idle_load | (complete & tx_nonempty);
  // A full RX FIFO still accepts a word when its head leaves in the same cycle.
  assign rx_push     = complete & (~rx_full | rx_pop);
  assign ovf_evt     = complete & rx_full & ~rx_pop;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    last_bit = 5'd31;
    rx_word  = rx_shift;
    case (len_q)
      2'd0:    begin last_bit = 5'd7;  rx_word = {24'b0, rx_shift[7:0]};  end
      2'd1:    begin last_bit = 5'd15; rx_word = {16'b0, rx_shift[15:0]}; end
      default: begin last_bit = 5'd31; rx_word = rx_shift;                end
    endcase
  end

  always_comb begin
    OUT_SPI_miso = tx_sr[31];
    case (len_sel)
      2'd0:    OUT_SPI_miso = tx_sr[7];
      2'd1:    OUT_SPI_miso = tx_sr[15];
      default: OUT_SPI_miso = tx_sr[31];
    endcase
  end

  always_comb begin
    state_next = state;
    first_edge = 1'b0;
    complete   = 1'b0;
    timeout    = 1'b0;
    idle_load  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          first_edge = 1'b1;
          state_next = SHIFT;
        end else if (!tx_loaded && tx_nonempty) begin
          idle_load = 1'b1;
        end
      end
      SHIFT: begin
        if (rise) begin
          if (bit_cnt == last_bit) begin
            complete   = 1'b1;
            state_next = IDLE;
          end
        end else if (to_cnt == TW'(IDLE_TIMEOUT - 1)) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_clk        <= 1'b0;
      len_q           <= '0;
      bit_cnt         <= '0;
      to_cnt          <= '0;
      rx_sr           <= '0;
      tx_sr           <= '0;
      tx_loaded       <= 1'b0;
      OUT_rxOverflow  <= 1'b0;
      OUT_txUnderflow <= 1'b0;
      OUT_frameErr    <= 1'b0;
    end else begin
      prev_clk        <= IN_SPI_clk;
      OUT_rxOverflow  <= ovf_evt;
      OUT_txUnderflow <= first_edge & ~tx_loaded;
      OUT_frameErr    <= timeout;
      if (rise) begin
        to_cnt <= '0;
        if (first_edge) len_q <= IN_frameLen;
        if (complete) begin
          rx_sr   <= '0;
          bit_cnt <= '0;
          if (tx_nonempty) begin
            tx_sr     <= tx_mem[tx_rd];
            tx_loaded <= 1'b1;
          end else begin
            tx_sr     <= '0;
            tx_loaded <= 1'b0;
          end
        end else begin
          rx_sr   <= rx_shift;
          tx_sr   <= {tx_sr[30:0], 1'b0};
          bit_cnt <= bit_cnt + 5'd1;
        end
      end else if (timeout) begin
        // The partially sent reply is abandoned along with the received bits.
        to_cnt    <= '0;
        bit_cnt   <= '0;
        rx_sr     <= '0;
        tx_sr     <= '0;
        tx_loaded <= 1'b0;
      end else begin
        if (state == SHIFT) to_cnt <= to_cnt + TW'(1);
        if (idle_load) begin
          tx_sr     <= tx_mem[tx_rd];
          tx_loaded <= 1'b1;
        end
      end
    end
  end

  // NOTE: FIFO storage is not reset; the reset pointers and counts make stale contents invisible.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= IN_txData;
    if (rx_push) rx_mem[rx_wr] <= rx_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + PW'(1);
      if (tx_pop)  tx_rd <= tx_rd + PW'(1);
      if (tx_push && !tx_pop)      tx_count <= tx_count + CW'(1);
      else if (!tx_push && tx_pop) tx_count <= tx_count - CW'(1);
      if (rx_push) rx_wr <= rx_wr + PW'(1);
      if (rx_pop)  rx_rd <= rx_rd + PW'(1);
      if (rx_push && !rx_pop)      rx_count <= rx_count + CW'(1);
      else if (!rx_push && rx_pop) rx_count <= rx_count - CW'(1);
    end
  end

  assign OUT_txReady = ~rst & (tx_count != CW'(FIFO_DEPTH));
  assign OUT_rxValid = (rx_count != '0);
  assign OUT_rxData  = OUT_rxValid ? rx_mem[rx_rd] : 32'b0;
  assign OUT_busy    = (state == SHIFT);

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: a bit-level SPI master model exchanges words with the
// responder while pulse monitors count overflow, underflow and frame-error events.
module tb_spi_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        spi_clk, spi_mosi, spi_miso;
  logic [1:0]  frame_len;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
  logic [31:0] tx_data, rx_data;
  logic        rx_ovf, tx_unf, frame_err, busy;

  int total = 0;
  int bad   = 0;
  int n_ovf = 0;
  int n_unf = 0;
  int n_ferr = 0;

  spi_responder #(.FIFO_DEPTH(2), .IDLE_TIMEOUT(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .IN_SPI_clk      (spi_clk),
    .IN_SPI_mosi     (spi_mosi),
    .OUT_SPI_miso    (spi_miso),
    .IN_frameLen     (frame_len),
    .IN_txValid      (tx_valid),
    .IN_txData       (tx_data),
    .OUT_txReady     (tx_ready),
    .OUT_rxValid     (rx_valid),
    .OUT_rxData      (rx_data),
    .IN_rxReady      (rx_ready),
    .OUT_rxOverflow  (rx_ovf),
    .OUT_txUnderflow (tx_unf),
    .OUT_frameErr    (frame_err),
    .OUT_busy        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_ovf)    n_ovf++;
      if (tx_unf)    n_unf++;
      if (frame_err) n_ferr++;
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Master: drives mosi from m[31] and shifts miso (sampled before each rising edge) into m.
  task automatic spi_xfer(input int nbits, input logic [31:0] m_in, output logic [31:0] m_out);
    logic [31:0] m;
    logic b;
    m = m_in;
    for (int i = 0; i < nbits; i++) begin
      spi_clk = 1'b0;
      tick(1);
      b        = spi_miso;
      spi_mosi = m[31];
      m        = {m[30:0], b};
      spi_clk  = 1'b1;
      tick(1);
    end
    spi_clk = 1'b0;
    tick(1);
    m_out = m;
  endtask

  task automatic push_tx(input logic [31:0] w);
    tx_valid = 1'b1;
    tx_data  = w;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic pop_rx();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    total++;
    if ({spi_miso, tx_ready, rx_valid, rx_ovf, tx_unf, frame_err, busy} !== 7'b0 || rx_data !== 32'h0) begin
      bad++;
      $display("FAIL reset_outputs: got flags=%b data=%h want all zero",
               {spi_miso, tx_ready, rx_valid, rx_ovf, tx_unf, frame_err, busy}, rx_data);
    end
    rst = 1'b0;
    tick(1);
    total++;
    if ({tx_ready, rx_valid, busy, spi_miso} !== 4'b1000) begin
      bad++;
      $display("FAIL post_reset: got ready/valid/busy/miso=%b want 1000",
               {tx_ready, rx_valid, busy, spi_miso});
    end
  endtask

  task automatic test_32bit();
    logic [31:0] m;
    int ev;
    frame_len = 2'd2;
    push_tx(32'hA5A50F0F);
    tick(2);
    ev = n_ovf + n_unf + n_ferr;
    spi_xfer(32, 32'h12345678, m);
    total++;
    if (m !== 32'hA5A50F0F) begin
      bad++;
      $display("FAIL f32_reply: got %h want a5a50f0f", m);
    end
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 32'h12345678) begin
      bad++;
      $display("FAIL f32_rx: got valid=%b data=%h want 1/12345678", rx_valid, rx_data);
    end
    total++;
    if (n_ovf + n_unf + n_ferr != ev) begin
      bad++;
      $display("FAIL f32_no_pulses: got %0d events want 0", n_ovf + n_unf + n_ferr - ev);
    end
    pop_rx();
    total++;
    if (rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL f32_pop: got rxValid=%b want 0", rx_valid);
    end
  endtask

  // Two 8-bit frames back to back: the second reply comes from the completion reload.
  task automatic test_back_to_back();
    logic [31:0] m;
    int unf0;
    frame_len = 2'd0;
    push_tx(32'h0000003C);
    push_tx(32'h00000081);
    tick(2);
    unf0 = n_unf;
    spi_xfer(8, 32'hC3000000, m);
    total++;
    if (m !== 32'h0000003C) begin
      bad++;
      $display("FAIL b2b_reply0: got %h want 0000003c", m);
    end
    spi_xfer(8, 32'h7E000000, m);
    total++;
    if (m !== 32'h00000081) begin
      bad++;
      $display("FAIL b2b_reply1: got %h want 00000081", m);
    end
    total++;
    if (rx_data !== 32'h000000C3) begin
      bad++;
      $display("FAIL b2b_rx0: got %h want 000000c3", rx_data);
    end
    pop_rx();
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 32'h0000007E) begin
      bad++;
      $display("FAIL b2b_rx1: got valid=%b data=%h want 1/0000007e", rx_valid, rx_data);
    end
    pop_rx();
    total++;
    if (rx_valid !== 1'b0 || n_unf != unf0) begin
      bad++;
      $display("FAIL b2b_end: got rxValid=%b underflows=%0d want 0/0", rx_valid, n_unf - unf0);
    end
  endtask

  task automatic test_timeout();
    logic [31:0] m;
    int ferr0;
    int err_at;
    frame_len = 2'd0;
    ferr0 = n_ferr;
    err_at = -1;
    spi_xfer(5, 32'hF8000000, m);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL to_busy: got %b want 1", busy);
    end
    for (int c = 1; c <= 100; c++) begin
      tick(1);
      if (frame_err === 1'b1 && err_at < 0) err_at = c;
    end
    // Last rising edge is one cycle before the loop; the pulse shows after 64 idle cycles.
    total++;
    if (err_at != 63) begin
      bad++;
      $display("FAIL to_when: got cycle %0d want 63", err_at);
    end
    total++;
    if (n_ferr - ferr0 != 1 || rx_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL to_state: got pulses=%0d rxValid=%b busy=%b want 1/0/0",
               n_ferr - ferr0, rx_valid, busy);
    end
    spi_xfer(8, 32'h5A000000, m);
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 32'h0000005A) begin
      bad++;
      $display("FAIL to_next_frame: got valid=%b data=%h want 1/0000005a", rx_valid, rx_data);
    end
    pop_rx();
  endtask

  task automatic test_overflow();
    logic [31:0] m;
    int ovf0;
    frame_len = 2'd0;
    rx_ready = 1'b0;
    ovf0 = n_ovf;
    spi_xfer(8, 32'h11000000, m);
    spi_xfer(8, 32'h22000000, m);
    total++;
    if (n_ovf != ovf0) begin
      bad++;
      $display("FAIL ovf_early: got %0d pulses want 0", n_ovf - ovf0);
    end
    spi_xfer(8, 32'h33000000, m);
    total++;
    if (n_ovf - ovf0 != 1) begin
      bad++;
      $display("FAIL ovf_pulse: got %0d pulses want 1", n_ovf - ovf0);
    end
    total++;
    if (rx_data !== 32'h00000011) begin
      bad++;
      $display("FAIL ovf_head0: got %h want 00000011", rx_data);
    end
    pop_rx();
    total++;
    if (rx_data !== 32'h00000022) begin
      bad++;
      $display("FAIL ovf_head1: got %h want 00000022", rx_data);
    end
    pop_rx();
    total++;
    if (rx_valid !== 1'b0) begin
      bad++;
      $display("FAIL ovf_empty: got rxValid=%b want 0", rx_valid);
    end
  endtask

  task automatic test_underflow();
    logic [31:0] m;
    int unf0;
    frame_len = 2'd1;
    unf0 = n_unf;
    spi_xfer(16, 32'hABCD0000, m);
    total++;
    if (n_unf - unf0 != 1) begin
      bad++;
      $display("FAIL unf_pulse: got %0d pulses want 1", n_unf - unf0);
    end
    total++;
    if (m !== 32'h00000000) begin
      bad++;
      $display("FAIL unf_miso: got master reg %h want 00000000", m);
    end
    total++;
    if (rx_data !== 32'h0000ABCD) begin
      bad++;
      $display("FAIL unf_rx: got %h want 0000abcd", rx_data);
    end
    pop_rx();
  endtask

  task automatic test_reset_midframe();
    logic [31:0] m;
    int unf0;
    frame_len = 2'd2;
    push_tx(32'h11111111);
    push_tx(32'h22222222);
    tick(2);
    spi_xfer(10, 32'hFFFFFFFF, m);
    rst = 1'b1;
    tick(1);
    total++;
    if ({spi_miso, tx_ready, rx_valid, rx_ovf, tx_unf, frame_err, busy} !== 7'b0 || rx_data !== 32'h0) begin
      bad++;
      $display("FAIL midrst_outputs: got flags=%b data=%h want all zero",
               {spi_miso, tx_ready, rx_valid, rx_ovf, tx_unf, frame_err, busy}, rx_data);
    end
    tick(1);
    rst = 1'b0;
    tick(1);
    total++;
    if ({tx_ready, rx_valid, busy} !== 3'b100) begin
      bad++;
      $display("FAIL midrst_after: got ready/valid/busy=%b want 100", {tx_ready, rx_valid, busy});
    end
    unf0 = n_unf;
    spi_xfer(32, 32'hDEADBEEF, m);
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL midrst_rx: got valid=%b data=%h want 1/deadbeef", rx_valid, rx_data);
    end
    total++;
    if (m !== 32'h00000000 || n_unf - unf0 != 1) begin
      bad++;
      $display("FAIL midrst_tx_flushed: got reply=%h underflows=%0d want 00000000/1", m, n_unf - unf0);
    end
    pop_rx();
  endtask

  initial begin
    rst       = 1'b1;
    spi_clk   = 1'b0;
    spi_mosi  = 1'b0;
    frame_len = 2'd0;
    tx_valid  = 1'b0;
    tx_data   = 32'h0;
    rx_ready  = 1'b0;
    tick(1);
    test_reset();
    test_32bit();
    test_back_to_back();
    test_timeout();
    test_overflow();
    test_underflow();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
